uart_sample_packer: RTL
=======================

# uart_sample_packer

Framing stage directly upstream of the UART transmitter. Buffers 16-bit demodulated audio samples in a small FIFO, optionally decimates them, and serialises each kept sample into a framed byte stream: sync byte, MSB, LSB, and an optional checksum. Bytes go out over a valid/ready handshake whose byte side matches the transmitter's `uart_data_i`/`valid_i`/`ready_o` ports.

## Interface

**Parameters**
- `DECIM`, default 1: keep one sample out of every `DECIM` accepted (legal 1..255).
- `FIFO_DEPTH`, default 4: sample FIFO entries (power of two, ≥2).

**Ports** (clock and reset first)
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `sample_i` in 16: demodulated sample, two's complement.
- `sample_valid_i` in 1: one-cycle strobe; `sample_i` is valid in that cycle.
- `uart_data_o` out 8: byte to the transmitter.
- `valid_o` out 1: `uart_data_o` is valid.
- `ready_i` in 1: transmitter ready; a byte transfers in any cycle with `valid_o && ready_i`.
- `overflow_o` out 1: sticky flag meaning a kept sample was dropped.

## Operation

**Decimation**
- An 8-bit counter advances on every `sample_valid_i` and wraps from `DECIM-1` to 0.
- A sample is kept when the counter is 0 at the strobe, so the first sample after reset is kept.

**FIFO**
- A kept sample is written at the strobe edge if the FIFO is not full.
- If the FIFO is full, the sample is dropped and `overflow_o` is set. It stays set until reset.
- Full is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs in that cycle.
- Pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally. Empty means pointers are equal; full means the MSBs differ and the rest are equal.

**FSM states:** IDLE, SYNC, HI, LO, CSUM.
- **IDLE:** `valid_o`=0. If the FIFO is not empty, pop the head into the 16-bit hold register and go to SYNC.
- **SYNC:** `uart_data_o`=0xA5, `valid_o`=1. On handshake go to HI.
- **HI:** `uart_data_o`=hold[15:8], `valid_o`=1. On handshake go to LO.
- **LO:** `uart_data_o`=hold[7:0], `valid_o`=1. On handshake go to CSUM when checksum is enabled, otherwise to IDLE.
- **CSUM:** `uart_data_o`=0xA5 ^ hold[15:8] ^ hold[7:0], `valid_o`=1. On handshake go to IDLE.

**Output behaviour**
- While `valid_o`=1 and `ready_i`=0, `uart_data_o` and the state are held stable.
- `valid_o` never drops without a handshake.
- Outputs decode only from the state and hold registers; there is no combinational path from `ready_i` or `sample_i` to any output.
- In IDLE, `uart_data_o` is 0x00.

**Storage capacity:** total is `FIFO_DEPTH`+1 samples (FIFO plus hold register).

**Reset**
- All outputs are 0, the FSM is in IDLE, the FIFO is empty, and the decimation counter is 0.
- Reset applied mid-frame aborts the frame immediately, and the partial frame is lost.

## Timing

- Strobe at cycle 0 with the FSM idle and the FIFO empty:
  - FIFO write at the end of cycle 0.
  - Pop at the end of cycle 1.
  - `valid_o`=1 with 0xA5 in cycle 2.
- With `ready_i` held at 1, frame bytes go out in consecutive cycles.
- Between frames there is one IDLE cycle, so the frame period is 4 cycles (5 with checksum).
- Throughput is bounded by the downstream `ready_i`. FIFO occupancy absorbs bursts.

## Configuration

- Macro: `UART_PACKER_CHECKSUM_EN`.
- **Defined:** CSUM state is compiled in and every frame is 4 bytes (A5, MSB, LSB, XOR checksum).
- **Undefined:** CSUM logic is absent, LO returns directly to IDLE, and frames are 3 bytes.

## Test plan

- **Single sample:** `DECIM`=1, `ready_i`=1, strobe `sample_i`=0x1234 → bytes A5, 12, 34 in cycles 2, 3, 4, then `valid_o`=0. With the macro, a fourth byte 0x83 follows in cycle 5.
- **Backpressure:** same stimulus, with `ready_i`=0 for 5 cycles while in HI → `uart_data_o` held at 0x12 and `valid_o`=1 for those cycles; 0x34 follows the first ready cycle.
- **Overflow:** `FIFO_DEPTH`=4, `ready_i`=0, strobe samples 0x0001..0x0006 in consecutive cycles → `overflow_o`=1 after the 6th strobe. Releasing `ready_i` yields exactly 5 frames with payloads 0x0001..0x0005, in order.
- **Decimation:** `DECIM`=3, strobe samples 0x0010..0x0015 → frames only for 0x0010 and 0x0013.
- **Reset mid-frame:** assert `rst`=0 while in HI → `valid_o`, `uart_data_o` and `overflow_o` go to 0 immediately. After release, a new 0xBEEF strobe yields A5, BE, EF.
- **Pointer wrap:** 20 single samples with `ready_i`=1, spaced 6 cycles apart → 20 correct frames, `overflow_o` stays 0.

Source files
------------

// File: rtl/uart_sample_packer.sv
// ---------------------------------------------------------------------------
// uart_sample_packer
//
// Framing stage in front of the UART transmitter. 16-bit audio samples are
// decimated (one kept out of every DECIM strobes), buffered in a small FIFO,
// and sent as a framed byte stream: 0xA5 sync, MSB, LSB and, when the
// UART_PACKER_CHECKSUM_EN macro is defined, an XOR checksum byte.
//
// Parameters
//   DECIM       keep one sample out of every DECIM accepted (1..255)
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 2)
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   sample_i        demodulated sample, two's complement
//   sample_valid_i  one-cycle strobe qualifying sample_i
//   uart_data_o     byte towards the transmitter
//   valid_o         uart_data_o is valid
//   ready_i         transmitter ready; a byte moves when valid_o && ready_i
//   overflow_o      sticky: a kept sample was dropped because the FIFO was full
//
// Configuration macro: UART_PACKER_CHECKSUM_EN (undefined -> 3-byte frames).
// ---------------------------------------------------------------------------
module uart_sample_packer #(
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    output logic [7:0]  uart_data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o
);

    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HI,
        LO
`ifdef UART_PACKER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Decimation: the counter is 0 on the strobe of every kept sample,
    // so the first sample after reset is always kept.
    // ------------------------------------------------------------------
    logic [7:0] decim_cnt;
    logic       keep;

    assign keep = sample_valid_i && (decim_cnt == 8'd0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decim_cnt <= 8'd0;
        end else if (sample_valid_i) begin
            decim_cnt <= (decim_cnt == DECIM_LAST) ? 8'd0 : decim_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO. Pointers carry one extra wrap bit; full is judged on the
    // registered pointers, so a same-cycle pop cannot make room for a write.
    // ------------------------------------------------------------------
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, wr_en, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en      = keep && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving the array unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en)              wr_ptr     <= wr_ptr + 1'b1;
            if (pop)                rd_ptr     <= rd_ptr + 1'b1;
            if (keep && fifo_full)  overflow_o <= 1'b1;
        end
    end

    // Hold register: the sample currently being framed.
    logic [15:0] hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= 16'h0000;
        end else if (pop) begin
            hold <= mem[rd_ptr[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM: state register / next state / output decode.
    // ------------------------------------------------------------------
    logic handshake;

    assign handshake = valid_o && ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!fifo_empty) state_nxt = SYNC;
            SYNC: if (handshake)   state_nxt = HI;
            HI:   if (handshake)   state_nxt = LO;
`ifdef UART_PACKER_CHECKSUM_EN
            LO:   if (handshake)   state_nxt = CSUM;
            CSUM: if (handshake)   state_nxt = IDLE;
`else
            LO:   if (handshake)   state_nxt = IDLE;
`endif
            default:               state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on state and hold, never on ready_i or sample_i.
    always_comb begin
        valid_o     = 1'b0;
        uart_data_o = 8'h00;
        unique case (state)
            IDLE: ;
            SYNC: begin
                valid_o     = 1'b1;
                uart_data_o = SYNC_BYTE;
            end
            HI: begin
                valid_o     = 1'b1;
                uart_data_o = hold[15:8];
            end
            LO: begin
                valid_o     = 1'b1;
                uart_data_o = hold[7:0];
            end
`ifdef UART_PACKER_CHECKSUM_EN
            CSUM: begin
                valid_o     = 1'b1;
                uart_data_o = SYNC_BYTE ^ hold[15:8] ^ hold[7:0];
            end
`endif
            default: ;
        endcase
    end

endmodule
